// File: rtl/synth_pkg.sv
// Shared definitions for the synthesizer's Avalon-ST sample source and the
// playback sample sink: FSM state encodings, CSR bit positions and the
// stream byte-order helper. Both ends call the same helper so that the
// packing on one side always matches the unpacking on the other.
package synth_pkg;

  // Playback FSM states. The encoding is visible in the CSR status word.
  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_PRIME    = 2'd1,
    ST_PLAY     = 2'd2
  } state_e;

  // CSR write-data bits.
  localparam int CSR_EN_BIT  = 0;
  localparam int CSR_CLR_BIT = 1;

  // The stream carries samples as {8'h00, s[7:0], s[15:8], s[23:16]}.
  // Reversing the three bytes is its own inverse, so packing and unpacking
  // both use this function.
  function automatic logic [23:0] byte_swap24(input logic [23:0] v);
    return {v[7:0], v[15:8], v[23:16]};
  endfunction

endpackage

// File: rtl/slow_clk_en.sv
// Clock-enable generator: pulses en for one clk cycle every
// CLK_HZ/OUT_HZ cycles (integer division, minimum 1). Free-running.
// Ports:
//   clk - system clock
//   rst - asynchronous active-high reset (counter cleared)
//   en  - one-cycle enable pulse
module slow_clk_en #(
  parameter int CLK_HZ = 100_000_000,
  parameter int OUT_HZ = 96_000
) (
  input  logic clk,
  input  logic rst,
  output logic en
);

  localparam int DIV = (CLK_HZ / OUT_HZ < 1) ? 1 : CLK_HZ / OUT_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign en = (cnt_q == LAST);

endmodule

// File: rtl/stream_sample_sink.sv
// Avalon-ST audio sink. Accepts byte-swapped 24-bit words from the DMA read
// channel into a FIFO and releases one signed sample per sample tick.
// Playback starts once PRIME_LEVEL words are buffered; an empty FIFO on a
// tick is an underrun, which re-primes and bumps a saturating counter.
// Ports:
//   clk, reset              - system clock, async active-high reset
//   asi_snk0_*              - stream sink (readyLatency 0)
//   avs_s0_write/writedata  - CSR write: bit0 enable, bit1 clear underruns
//   avs_s0_read/readdata    - CSR read, registered, valid one cycle later:
//                             {underruns[15:0], state[1:0], 6'b0, fill[7:0]}
//   o_sample, o_sample_stb  - sample and its one-cycle strobe
module stream_sample_sink
  import synth_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int SAMPLE_HZ   = 96_000,
  parameter int DEPTH       = 64,
  parameter int PRIME_LEVEL = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] asi_snk0_data,
  input  logic        asi_snk0_valid,
  output logic        asi_snk0_ready,
  input  logic        avs_s0_write,
  input  logic [31:0] avs_s0_writedata,
  input  logic        avs_s0_read,
  output logic [31:0] avs_s0_readdata,
  output logic [23:0] o_sample,
  output logic        o_sample_stb
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [23:0]   sample_q, sample_d;
  logic          stb_q;
  logic [15:0]   urun_q, urun_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [23:0]   mem_q [DEPTH];

  logic tick, full, push, pop;
  logic enable_req, disable_req, clear_req;

  slow_clk_en #(
    .CLK_HZ(CLK_HZ),
    .OUT_HZ(SAMPLE_HZ)
  ) u_tick (
    .clk(clk),
    .rst(reset),
    .en (tick)
  );

  // Upper data byte and unused CSR bits are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{asi_snk0_data[31:24], avs_s0_writedata[31:2]};

  assign full           = (fill_q == FW'(DEPTH));
  assign asi_snk0_ready = (state_q != ST_DISABLED) && !full;
  assign push           = asi_snk0_valid && asi_snk0_ready;

  assign enable_req  = avs_s0_write &&  avs_s0_writedata[CSR_EN_BIT];
  assign disable_req = avs_s0_write && !avs_s0_writedata[CSR_EN_BIT];
  assign clear_req   = avs_s0_write &&  avs_s0_writedata[CSR_CLR_BIT];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d  = state_q;
    sample_d = sample_q;
    urun_d   = urun_q;
    pop      = 1'b0;

    unique case (state_q)
      ST_DISABLED: begin
        sample_d = '0;
        if (enable_req) state_d = ST_PRIME;
      end
      ST_PRIME: begin
        if (tick) sample_d = '0;
        // Uses the registered fill, so the switch lands the cycle after
        // the push that reached the level.
        if (fill_q >= FW'(PRIME_LEVEL)) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (tick) begin
          if (fill_q != '0) begin
            pop      = 1'b1;
            sample_d = mem_q[rd_ptr_q];
          end else begin
            sample_d = '0;
            urun_d   = (urun_q == 16'hFFFF) ? urun_q : urun_q + 16'd1;
            state_d  = ST_PRIME;
          end
        end
      end
      default: state_d = ST_DISABLED;
    endcase

    // Disable overrides anything the state logic decided this cycle.
    if (disable_req) begin
      state_d  = ST_DISABLED;
      sample_d = '0;
      pop      = 1'b0;
    end

    // Clear wins over a coincident underrun increment.
    if (clear_req) urun_d = '0;

    // Entering or sitting in DISABLED flushes the FIFO; a word accepted in
    // the disabling cycle is discarded along with the rest.
    if (state_d == ST_DISABLED) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      fill_d   = fill_q + FW'(push) - FW'(pop);
    end

    rdata_d = avs_s0_read ? {urun_q, state_q, 6'b0, 8'(fill_q)} : rdata_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_DISABLED;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      sample_q <= '0;
      stb_q    <= 1'b0;
      urun_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      sample_q <= sample_d;
      stb_q    <= tick;
      urun_q   <= urun_d;
      rdata_q  <= rdata_d;
    end
  end

  // NOTE: the storage array has no reset; fill and pointers alone decide
  // which entries are meaningful, so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= byte_swap24(asi_snk0_data[23:0]);
  end

  assign o_sample        = sample_q;
  assign o_sample_stb    = stb_q;
  assign avs_s0_readdata = rdata_q;

endmodule

// File: tb/tb_stream_sample_sink.sv
// Directed bench for stream_sample_sink: divider of 10, 4-deep FIFO,
// prime level 2. A vector table covers byte order, priming, underrun and
// counter clear; hand sequences cover push/pop on a tick, backpressure,
// disable flushing and asynchronous reset.
module tb_stream_sample_sink;

  localparam int CLK_HZ = 100;
  localparam int SMP_HZ = 10;
  localparam int DEPTH  = 4;
  localparam int PRIME  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] asi_snk0_data = '0;
  logic        asi_snk0_valid = 1'b0;
  logic        asi_snk0_ready;
  logic        avs_s0_write = 1'b0;
  logic [31:0] avs_s0_writedata = '0;
  logic        avs_s0_read = 1'b0;
  logic [31:0] avs_s0_readdata;
  logic [23:0] o_sample;
  logic        o_sample_stb;

  int n_chk = 0;
  int n_err = 0;

  stream_sample_sink #(
    .CLK_HZ(CLK_HZ), .SAMPLE_HZ(SMP_HZ), .DEPTH(DEPTH), .PRIME_LEVEL(PRIME)
  ) dut (
    .clk(clk), .reset(reset),
    .asi_snk0_data(asi_snk0_data), .asi_snk0_valid(asi_snk0_valid),
    .asi_snk0_ready(asi_snk0_ready),
    .avs_s0_write(avs_s0_write), .avs_s0_writedata(avs_s0_writedata),
    .avs_s0_read(avs_s0_read), .avs_s0_readdata(avs_s0_readdata),
    .o_sample(o_sample), .o_sample_stb(o_sample_stb)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  typedef enum {OP_WRITE, OP_PUSH, OP_IDLE, OP_READ, OP_TICK} op_e;
  typedef struct {
    op_e         op;
    logic [31:0] arg;
    logic [31:0] exp;
    string       name;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [31:0] wd);
    avs_s0_write = 1'b1;
    avs_s0_writedata = wd;
    step();
    avs_s0_write = 1'b0;
    avs_s0_writedata = '0;
  endtask

  task automatic csr_read(output logic [31:0] rd);
    avs_s0_read = 1'b1;
    step();
    avs_s0_read = 1'b0;
    rd = avs_s0_readdata;
  endtask

  task automatic push(input logic [31:0] w, input string nm);
    bit ok = 1'b0;
    asi_snk0_data = w;
    asi_snk0_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (asi_snk0_ready) begin
        ok = 1'b1;
        step();
        break;
      end
      step();
    end
    asi_snk0_valid = 1'b0;
    check({nm, "_accept"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_tick(input string nm, input logic [23:0] exp);
    bit seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (o_sample_stb) begin
        seen = 1'b1;
        break;
      end
    end
    check({nm, "_stb"}, 32'(seen), 32'd1);
    check({nm, "_sample"}, {8'h00, o_sample}, {8'h00, exp});
  endtask

  // Holds valid high for n cycles, counting accepted words; each accepted
  // word is replaced by a fresh one.
  task automatic hold_valid(input int n, output int acc);
    acc = 0;
    for (int i = 0; i < n; i++) begin
      if (asi_snk0_ready) begin
        acc++;
        step();
        asi_snk0_data = {8'h00, 8'hB0, 8'hB0, 8'(acc)};
      end else begin
        step();
      end
    end
  endtask

  logic [31:0] rd;
  int acc;

  initial begin
    vecs[0]  = '{OP_TICK,  32'h0,        32'h0,        "dis_tick"};
    vecs[1]  = '{OP_WRITE, 32'h1,        32'h0,        "en"};
    vecs[2]  = '{OP_PUSH,  32'h00563412, 32'h0,        "push_a"};
    vecs[3]  = '{OP_PUSH,  32'hAAFFFF80, 32'h0,        "push_b"};
    vecs[4]  = '{OP_IDLE,  32'h0,        32'h0,        "idle"};
    vecs[5]  = '{OP_READ,  32'h0,        32'h0000_8002, "stat_play"};
    vecs[6]  = '{OP_TICK,  32'h0,        32'h0012_3456, "order_pos"};
    vecs[7]  = '{OP_TICK,  32'h0,        32'h0080_FFFF, "order_neg"};
    vecs[8]  = '{OP_TICK,  32'h0,        32'h0,        "underrun"};
    vecs[9]  = '{OP_READ,  32'h0,        32'h0001_4000, "stat_urun"};
    vecs[10] = '{OP_WRITE, 32'h3,        32'h0,        "clr_en"};
    vecs[11] = '{OP_READ,  32'h0,        32'h0000_4000, "stat_clr"};
    vecs[12] = '{OP_TICK,  32'h0,        32'h0,        "prime_sync"};
    vecs[13] = '{OP_PUSH,  32'h00030201, 32'h0,        "push_p1"};
    vecs[14] = '{OP_READ,  32'h0,        32'h0000_4001, "stat_prime"};
    vecs[15] = '{OP_TICK,  32'h0,        32'h0,        "prime_hold"};
    vecs[16] = '{OP_PUSH,  32'h00060504, 32'h0,        "push_p2"};
    vecs[17] = '{OP_IDLE,  32'h0,        32'h0,        "idle"};
    vecs[18] = '{OP_READ,  32'h0,        32'h0000_8002, "stat_primed"};
    vecs[19] = '{OP_TICK,  32'h0,        32'h0001_0203, "prime_first"};

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    step();
    check("rst_ready", 32'(asi_snk0_ready), 32'd0);
    check("rst_stb", 32'(o_sample_stb), 32'd0);
    check("rst_sample", {8'h00, o_sample}, 32'h0);
    check("rst_rdata", avs_s0_readdata, 32'h0);

    for (int i = 0; i < NV; i++) begin
      case (vecs[i].op)
        OP_WRITE: csr_write(vecs[i].arg);
        OP_PUSH:  push(vecs[i].arg, vecs[i].name);
        OP_IDLE:  step();
        OP_READ: begin
          csr_read(rd);
          check(vecs[i].name, rd, vecs[i].exp);
        end
        OP_TICK:  wait_tick(vecs[i].name, vecs[i].exp[23:0]);
        default:  step();
      endcase
    end

    // Push and pop on the same tick cycle at fill 2: FIFO holds 040506 now.
    push(32'h00090807, "pp_fill");
    repeat (8) step();
    push(32'h000C0B0A, "pp_push");
    check("pp_stb", 32'(o_sample_stb), 32'd1);
    check("pp_sample", {8'h00, o_sample}, 32'h0004_0506);
    csr_read(rd);
    check("pp_stat", rd, 32'h0000_8002);

    // Backpressure: fill 1 after this tick, then three accepts to full.
    wait_tick("bp_sync", 24'h070809);
    asi_snk0_data = 32'h00B0B000;
    asi_snk0_valid = 1'b1;
    hold_valid(7, acc);
    check("bp_accepts", 32'(acc), 32'd3);
    check("bp_ready_full", 32'(asi_snk0_ready), 32'd0);
    csr_read(rd);
    check("bp_stat_full", rd, 32'h0000_8004);
    hold_valid(6, acc);
    check("bp_after_tick", 32'(acc), 32'd1);
    asi_snk0_valid = 1'b0;
    check("bp_popped", {8'h00, o_sample}, 32'h000A_0B0C);
    csr_read(rd);
    check("bp_stat_refill", rd, 32'h0000_8004);

    // Disable with a full FIFO.
    csr_write(32'h0);
    check("dis_ready", 32'(asi_snk0_ready), 32'd0);
    check("dis_sample", {8'h00, o_sample}, 32'h0);
    csr_read(rd);
    check("dis_stat", rd, 32'h0);

    // Word offered in the disabling cycle is accepted, then flushed.
    csr_write(32'h1);
    push(32'h00EFCDAB, "dacc_pre");
    asi_snk0_data = 32'h00111111;
    asi_snk0_valid = 1'b1;
    avs_s0_write = 1'b1;
    avs_s0_writedata = 32'h0;
    check("dacc_ready", 32'(asi_snk0_ready), 32'd1);
    step();
    asi_snk0_valid = 1'b0;
    avs_s0_write = 1'b0;
    csr_read(rd);
    check("dacc_stat", rd, 32'h0);
    wait_tick("dis_stb", 24'h0);

    // Asynchronous reset in the middle of playback.
    csr_write(32'h1);
    push(32'h00332211, "rst_p1");
    push(32'h00665544, "rst_p2");
    step();
    csr_read(rd);
    check("play_stat", rd, 32'h0000_8002);
    wait_tick("play_tick", 24'h112233);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("arst_sample", {8'h00, o_sample}, 32'h0);
    check("arst_stb", 32'(o_sample_stb), 32'd0);
    check("arst_ready", 32'(asi_snk0_ready), 32'd0);
    check("arst_rdata", avs_s0_readdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step();
    csr_read(rd);
    check("post_rst_stat", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/stream_sample_sink.md
Name: stream_sample_sink

Overview:
Avalon-ST sink that accepts byte-swapped 24-bit audio words from the mSGDMA read channel. It buffers them in an internal FIFO and releases one signed sample per 96 kHz tick to the DAC path. It is the playback counterpart of the synthesizer's Avalon-ST sample source. A one-word Avalon-MM CSR provides enable, clear and status readback.

Parameters:
CLK_HZ, 100_000_000, system clock frequency
SAMPLE_HZ, 96_000, output sample rate
DEPTH, 64, FIFO depth in samples; power of two, 4..128
PRIME_LEVEL, 16, fill level required before playback starts or resumes; 1..DEPTH

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
asi_snk0_data  in  32  stream word {8'h00, s[7:0], s[15:8], s[23:16]}
asi_snk0_valid  in  1  stream word valid
asi_snk0_ready  out  1  sink ready; readyLatency 0
avs_s0_write  in  1  CSR write strobe
avs_s0_writedata  in  32  bit0 = enable, bit1 = clear underrun count (self-clearing)
avs_s0_read  in  1  CSR read strobe
avs_s0_readdata  out  32  status word
o_sample  out  24  signed sample to DAC/mixer
o_sample_stb  out  1  one-cycle strobe, high on every sample tick

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, FIFO empty, enable 0, state DISABLED, underrun count 0, tick divider 0.
- Tick: internal divider pulses tick for one clk every CLK_HZ/SAMPLE_HZ cycles (integer division). The divider runs regardless of state.
- Ready: asi_snk0_ready = enable && !full. This is combinational from registered state only. A word is accepted when valid && ready in the same cycle.
- Unpack on accept: s = {d[7:0], d[15:8], d[23:16]}. Bits d[31:24] are ignored.
- FIFO behaviour:
  - Push and pop in the same cycle both take effect; fill is unchanged.
  - No push when full, since ready is low.
  - Pointers wrap modulo DEPTH.
- States:
  - DISABLED: o_sample is held at 0. Stream is not ready. FIFO is flushed on entry.
  - PRIME: accepts stream words. o_sample = 0 on each tick. Go to PLAY when fill >= PRIME_LEVEL, evaluated on the cycle after the push.
  - PLAY: on tick with fill > 0, pop the head and register it to o_sample. Latency from tick to o_sample is 1 cycle, and o_sample_stb is aligned with the o_sample update. On tick with fill == 0 (underrun): o_sample <= 0, underrun count +1 (saturating at 16'hFFFF), go to PRIME.
- o_sample_stb behaviour: asserted one cycle after every tick in every state, including DISABLED, where o_sample stays 0.
- Enable transitions:
  - Write with bit0 = 1 while DISABLED goes to PRIME.
  - Write with bit0 = 0 in any state goes to DISABLED and flushes the FIFO the next cycle. A stream word presented in that same cycle is still accepted, then flushed.
- Clear: write with bit1 = 1 zeroes the underrun count. If clear coincides with an underrun, clear wins and the count is 0.
- CSR read: avs_s0_readdata is registered and valid the cycle after avs_s0_read. Otherwise it holds its last value.
  - [31:16] underrun count
  - [15:14] state: 0 DISABLED, 1 PRIME, 2 PLAY
  - [13:8] zero
  - [7:0] fill level, 0..DEPTH
- Reset mid-transfer: any in-flight word is dropped, and the upstream DMA is expected to be restarted by software.

Decomposition:
- Shared package (synth_pkg): state encodings ST_DISABLED/ST_PRIME/ST_PLAY, CSR bit positions, and the byte-swap function. The source side uses the same function, keeping both ends consistent.
- One sub-module: reuse the existing slow_clk_en(CLK_HZ, SAMPLE_HZ) for tick generation.
- FIFO is inline register array plus pointers. Avoid the dual-clock IP, because fill-level readback is needed.

Test Plan:
- Byte order: CLK_HZ=100, SAMPLE_HZ=10, PRIME_LEVEL=1. Enable, push 32'h00563412 -> o_sample = 24'h123456 with stb on the next tick. Push 32'h00FFFF80 -> o_sample = 24'h80FFFF (negative).
- Priming: PRIME_LEVEL=4, push 3 words -> state reads 1 and o_sample stays 0 across ticks. Push a 4th word -> state 2, and the first word appears on the next tick.
- Backpressure: DEPTH=4, valid held high with no ticks -> ready drops after 4 accepts and fill reads 4. After one tick -> exactly one more word is accepted.
- Underrun: PRIME_LEVEL=2, push 2 words, let 3 ticks pass -> two samples out, then o_sample=0, count=1, state=1. Write bit1 together with bit0 -> count 0 while enable is kept.
- Simultaneous push/pop at fill=2 on a tick cycle -> fill remains 2 and the popped sample is the older word.
- Disable/reset: disable with fill=5 -> fill 0, ready 0, o_sample 0. Assert reset mid-play -> all outputs 0 immediately, asynchronously.
